// File: rtl/aes128_cipher_core.sv
// Iterative AES-128 encryption core, one round per clock, valid/ready on both sides.
// Ports: clk, rst_n (sync, active low); in_valid/in_ready with plaintext and
// expandedKeys (11 round keys, key 0 at the MSBs); out_valid/out_ready with
// ciphertext; busy is high while a block is being processed or held for output.
module aes128_cipher_core #(
  parameter int NR = 10
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [127:0]    plaintext,
  input  logic [1407:0]   expandedKeys,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [127:0]    ciphertext,
  output logic            busy
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } fsm_t;

  localparam logic [3:0] LAST = 4'(NR);

  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5,
    8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0,
    8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc,
    8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a,
    8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0,
    8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b,
    8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85,
    8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5,
    8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17,
    8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88,
    8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c,
    8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9,
    8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6,
    8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e,
    8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94,
    8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68,
    8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // SubBytes, ShiftRows and (unless last) MixColumns on a column-major state
  // where byte i = row (i%4), column (i/4), byte 0 at the MSBs.
  function automatic logic [127:0] round_fn(
    input logic [127:0] s,
    input logic         last
  );
    logic [7:0] b [16];
    logic [7:0] t [16];
    logic [7:0] a0, a1, a2, a3;
    logic [127:0] r;
    for (int i = 0; i < 16; i++)
      b[i] = SBOX[s[127-8*i -: 8]];
    for (int c = 0; c < 4; c++)
      for (int w = 0; w < 4; w++)
        t[4*c+w] = b[4*((c+w)%4)+w];
    if (!last) begin
      for (int c = 0; c < 4; c++) begin
        a0 = t[4*c];
        a1 = t[4*c+1];
        a2 = t[4*c+2];
        a3 = t[4*c+3];
        t[4*c]   = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
        t[4*c+1] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
        t[4*c+2] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
        t[4*c+3] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
      end
    end
    r = '0;
    for (int i = 0; i < 16; i++)
      r[127-8*i -: 8] = t[i];
    return r;
  endfunction

  fsm_t         fsm;
  logic [3:0]   round;
  logic [127:0] st;
  logic [127:0] rk [NR+1];
  logic [127:0] next_st;

  for (genvar r = 0; r <= NR; r++) begin : g_rk
    assign rk[r] = expandedKeys[1407-128*r -: 128];
  end

  always_comb begin
    next_st = round_fn(st, round == LAST) ^ rk[round];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fsm       <= S_IDLE;
      round     <= '0;
      st        <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      unique case (fsm)
        S_IDLE: begin
          if (in_valid) begin
            st       <= plaintext ^ rk[0];
            round    <= 4'd1;
            fsm      <= S_RUN;
            in_ready <= 1'b0;
            busy     <= 1'b1;
          end
        end
        S_RUN: begin
          st    <= next_st;
          round <= round + 4'd1;
          if (round == LAST) begin
            round     <= '0;
            fsm       <= S_DONE;
            out_valid <= 1'b1;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            fsm       <= S_IDLE;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
          end
        end
        default: fsm <= S_IDLE;
      endcase
    end
  end

  assign ciphertext = st;

endmodule

// File: tb/tb_aes128_cipher_core.sv
// Scoreboard bench for aes128_cipher_core with a byte-level AES reference model.
// Drives FIPS-197 vectors, backpressure, back-to-back, reset-abort and random blocks.
module tb_aes128_cipher_core;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [127:0]  plaintext;
  logic [1407:0] expandedKeys;
  logic          out_valid;
  logic          out_ready;
  logic [127:0]  ciphertext;
  logic          busy;

  always #5 clk = ~clk;

  aes128_cipher_core dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .plaintext    (plaintext),
    .expandedKeys (expandedKeys),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .ciphertext   (ciphertext),
    .busy         (busy)
  );

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [127:0] ct;
    int           acc;
  } exp_t;

  exp_t sq[$];

  logic [7:0] sb [256];

  task automatic check(input string name, input logic [127:0] act,
                       input logic [127:0] want);
    n_cmp++;
    if (act !== want) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, want);
    end
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    logic [7:0] y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
      y = y >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
    logic [15:0] d;
    d = {v, v} << n;
    return d[15:8];
  endfunction

  // S-box from its definition: GF(2^8) inverse followed by the affine map.
  task automatic build_sbox();
    logic [7:0] inv;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sb[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3)
              ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  function automatic logic [1407:0] expand(input logic [127:0] key);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rc = 8'h01;
    logic [1407:0] ek = '0;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sb[t[31:24]], sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]};
        t = t ^ {rc, 24'h0};
        rc = gmul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int i = 0; i < 44; i++) ek[1407-32*i -: 32] = w[i];
    return ek;
  endfunction

  function automatic logic [127:0] encrypt(input logic [127:0] pt,
                                           input logic [1407:0] ek);
    logic [7:0] s [16];
    logic [7:0] t [16];
    logic [7:0] a0, a1, a2, a3;
    logic [127:0] rk;
    logic [127:0] res = '0;
    for (int i = 0; i < 16; i++) s[i] = pt[127-8*i -: 8];
    for (int r = 0; r <= 10; r++) begin
      if (r > 0) begin
        for (int i = 0; i < 16; i++) s[i] = sb[s[i]];
        for (int c = 0; c < 4; c++)
          for (int w = 0; w < 4; w++)
            t[4*c+w] = s[4*((c+w)%4)+w];
        s = t;
        if (r < 10) begin
          for (int c = 0; c < 4; c++) begin
            a0 = s[4*c]; a1 = s[4*c+1]; a2 = s[4*c+2]; a3 = s[4*c+3];
            s[4*c]   = gmul(8'h02, a0) ^ gmul(8'h03, a1) ^ a2 ^ a3;
            s[4*c+1] = a0 ^ gmul(8'h02, a1) ^ gmul(8'h03, a2) ^ a3;
            s[4*c+2] = a0 ^ a1 ^ gmul(8'h02, a2) ^ gmul(8'h03, a3);
            s[4*c+3] = gmul(8'h03, a0) ^ a1 ^ a2 ^ gmul(8'h02, a3);
          end
        end
      end
      rk = ek[1407-128*r -: 128];
      for (int i = 0; i < 16; i++) s[i] = s[i] ^ rk[127-8*i -: 8];
    end
    for (int i = 0; i < 16; i++) res[127-8*i -: 8] = s[i];
    return res;
  endfunction

  // Monitor: latency on out_valid rise, ciphertext on each handshake.
  logic prev_ov = 1'b0;
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n && out_valid && !prev_ov && sq.size() > 0)
        check("latency", 128'(cyc - sq[0].acc), 128'd10);
      if (rst_n && out_valid && out_ready) begin
        if (sq.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_output: got %h expected none", ciphertext);
        end else begin
          check("ciphertext", ciphertext, sq[0].ct);
          void'(sq.pop_front());
        end
      end
      prev_ov = out_valid;
    end
  end

  // Presents a block and returns just after the accepting edge, in_valid still high.
  task automatic present(input logic [127:0] pt, input logic [1407:0] ek,
                         input logic [127:0] want, output int acc);
    int n = 0;
    plaintext = pt;
    expandedKeys = ek;
    in_valid = 1'b1;
    acc = -1;
    @(negedge clk);
    while (!in_ready && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      n_cmp++;
      n_err++;
      $display("FAIL accept_timeout: got in_ready 0 expected 1");
      in_valid = 1'b0;
    end else begin
      @(posedge clk);
      #1;
      acc = cyc;
      sq.push_back('{ct: want, acc: acc});
    end
  endtask

  task automatic drain();
    int n = 0;
    while (sq.size() > 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("drain", 128'(sq.size()), 128'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  localparam logic [127:0] KB  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] PTB = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] CTB = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] KC  = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] PTC = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CTC = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  initial begin
    logic [1407:0] ekb, ekc, ek;
    logic [127:0]  key, pt;
    int a1, a2, k, n;

    rst_n = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    plaintext = '0;
    expandedKeys = '0;
    build_sbox();
    ekb = expand(KB);
    ekc = expand(KC);

    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", 128'(out_valid), 128'd0);
    check("rst_ciphertext", ciphertext, 128'd0);
    check("rst_busy", 128'(busy), 128'd0);
    check("rst_in_ready", 128'(in_ready), 128'd1);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // FIPS-197 appendix B and C.1
    present(PTB, ekb, CTB, a1);
    in_valid = 1'b0;
    drain();
    present(PTC, ekc, CTC, a1);
    in_valid = 1'b0;
    drain();

    // Backpressure
    out_ready = 1'b0;
    present(PTB, ekb, CTB, a1);
    in_valid = 1'b0;
    n = 0;
    @(negedge clk);
    while (!out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("bp_out_valid_rise", 128'(out_valid), 128'd1);
    in_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      check("bp_ciphertext", ciphertext, CTB);
      check("bp_in_ready", 128'(in_ready), 128'd0);
      check("bp_out_valid", 128'(out_valid), 128'd1);
      @(negedge clk);
    end
    in_valid = 1'b0;
    @(posedge clk);
    #1 out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("bp_after_in_ready", 128'(in_ready), 128'd1);
    check("bp_after_out_valid", 128'(out_valid), 128'd0);
    drain();

    // Back-to-back with in_valid held high
    present(PTB, ekb, CTB, a1);
    repeat (10) @(posedge clk);
    #1;
    present(PTC, ekc, CTC, a2);
    in_valid = 1'b0;
    check("b2b_spacing", 128'(a2 - a1), 128'd12);
    drain();

    // Reset during round 5 aborts the block
    present(PTB, ekb, CTB, a1);
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    sq.delete();
    @(negedge clk);
    check("abort_out_valid", 128'(out_valid), 128'd0);
    check("abort_ciphertext", ciphertext, 128'd0);
    check("abort_in_ready", 128'(in_ready), 128'd1);
    check("abort_busy", 128'(busy), 128'd0);
    @(posedge clk);
    #1;
    present(PTB, ekb, CTB, a1);
    in_valid = 1'b0;
    drain();

    // Stale in_valid during RUN
    present(PTC, ekc, CTC, a1);
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    in_valid = 1'b1;
    plaintext = {$urandom, $urandom, $urandom, $urandom};
    repeat (3) @(posedge clk);
    #1 in_valid = 1'b0;
    drain();

    // Random blocks with random output stalls
    for (int it = 0; it < 20; it++) begin
      key = {$urandom, $urandom, $urandom, $urandom};
      pt = {$urandom, $urandom, $urandom, $urandom};
      ek = expand(key);
      present(pt, ek, encrypt(pt, ek), a1);
      in_valid = 1'b0;
      repeat (10) @(posedge clk);
      #1 out_ready = 1'b0;
      k = $urandom_range(0, 3);
      repeat (k) @(posedge clk);
      #1 out_ready = 1'b1;
    end
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
